// File: rtl/tx_module_pkg.sv
// tx_module_pkg: shared UART constants, FSM state encoding and parity helper
package tx_module_pkg;
  localparam int BPS_9600   = 5208;
  localparam int BPS_115200 = 434;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } tx_state_t;
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/tx_module_bps.sv
// tx_module_bps: baud counter producing a one-cycle tick on the last clock of each bit
module tx_module_bps #(
  parameter int BPS_CNT = 434
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);
  localparam logic [15:0] LAST = 16'(BPS_CNT - 1);
  logic [15:0] r_cnt;
  // count 0..BPS_CNT-1 and wrap; clearing keeps every frame bit-aligned
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 16'd1;
  end
  assign o_tick = i_en && !i_clear && (r_cnt == LAST);
endmodule

// File: rtl/tx_module.sv
// tx_module: UART transmitter, start + 8 data LSB-first + optional even parity + 1/2 stop bits
module tx_module
  import tx_module_pkg::*;
#(
  parameter int BPS_CNT   = 434,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TX_Pin_Out
);
  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic       r_par;
  logic [2:0] r_bit;
  logic       r_armed;
  logic       w_tick;
  logic       w_idle;

  assign w_idle = (r_state == ST_IDLE);

  tx_module_bps #(.BPS_CNT(BPS_CNT)) u_bps (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_clear(w_idle),
    .i_en   (!w_idle),
    .o_tick (w_tick)
  );

  // frame sequencer: all line/handshake outputs registered here; arming needs En seen low after Done
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_bit       <= '0;
      r_armed     <= 1'b1;
      TX_Done_Sig <= 1'b0;
      TX_Busy     <= 1'b0;
      TX_Pin_Out  <= 1'b1;
    end else begin
      if (!TX_En_Sig) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          TX_Pin_Out <= 1'b1;
          if (TX_En_Sig && r_armed) begin
            r_shift    <= TX_Data;
            r_par      <= even_parity(TX_Data);
            r_bit      <= '0;
            TX_Pin_Out <= 1'b0;
            TX_Busy    <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: if (w_tick) begin
          TX_Pin_Out <= r_shift[0];
          r_shift    <= r_shift >> 1;
          r_state    <= ST_DATA;
        end
        ST_DATA: if (w_tick) begin
          if (r_bit == 3'd7) begin
            r_bit      <= '0;
            TX_Pin_Out <= (PARITY_EN != 0) ? r_par : 1'b1;
            r_state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            r_bit      <= r_bit + 3'd1;
            TX_Pin_Out <= r_shift[0];
            r_shift    <= r_shift >> 1;
          end
        end
        ST_PARITY: if (w_tick) begin
          TX_Pin_Out <= 1'b1;
          r_state    <= ST_STOP;
        end
        ST_STOP: if (w_tick) begin
          if (r_bit == 3'(STOP_BITS - 1)) begin
            r_bit       <= '0;
            TX_Done_Sig <= 1'b1;
            r_state     <= ST_DONE;
          end else r_bit <= r_bit + 3'd1;
        end
        ST_DONE: begin
          TX_Done_Sig <= 1'b0;
          TX_Busy     <= 1'b0;
          r_armed     <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_module.sv
// tb_tx_module: directed checks of tx_module framing, handshake, re-arm and async reset
module tb_tx_module;
  logic            clk;
  logic            rst_n;
  logic [1:0]      en;
  logic [1:0][7:0] data;
  logic [1:0]      pin;
  logic [1:0]      done;
  logic [1:0]      busy;
  int              checks;
  int              errors;

  tx_module #(.BPS_CNT(8), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[0]), .TX_Data(data[0]),
    .TX_Done_Sig(done[0]), .TX_Busy(busy[0]), .TX_Pin_Out(pin[0])
  );
  tx_module #(.BPS_CNT(8), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[1]), .TX_Data(data[1]),
    .TX_Done_Sig(done[1]), .TX_Busy(busy[1]), .TX_Pin_Out(pin[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests one frame on dut d and checks every bit mid-bit, Done timing and Busy.
  // Bit k of the frame occupies negedge samples c = 8k .. 8k+7 after the START edge.
  task automatic frame(input int d, input logic [7:0] b, input int par_en,
                       input logic exp_par, input int stops, input int drop_at);
    logic [11:0] bits;
    int nb, w, dones, done_at;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (par_en != 0) bits[9] = exp_par;
    nb = 9 + par_en + stops;
    en[d] = 1'b1;
    data[d] = b;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (pin[d] !== 1'b0 && w < 20);
    chk($sformatf("d%0d_%02h_start_lat", d, b), w, 1);
    chk($sformatf("d%0d_%02h_busy_start", d, b), 32'(busy[d]), 1);
    dones = 0;
    done_at = -1;
    for (int c = 0; c <= nb * 8 + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) begin
        en[d] = 1'b0;
        data[d] = 8'hFF;
      end
      if (c % 8 == 4 && c / 8 < nb)
        chk($sformatf("d%0d_%02h_bit%0d", d, b, c / 8), 32'(pin[d]), 32'(bits[c/8]));
      if (c == nb * 8) chk($sformatf("d%0d_%02h_busy_done", d, b), 32'(busy[d]), 1);
      if (done[d] === 1'b1) begin
        dones++;
        done_at = c;
      end
    end
    chk($sformatf("d%0d_%02h_done_count", d, b), dones, 1);
    chk($sformatf("d%0d_%02h_done_at", d, b), done_at, nb * 8);
    chk($sformatf("d%0d_%02h_busy_after", d, b), 32'(busy[d]), 0);
  endtask

  initial begin
    int bad, w;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pin", 32'(pin), 32'h3);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pin !== 2'b11 || busy !== 2'b00 || done !== 2'b00) bad++;
    end
    chk("idle_quiet", bad, 0);

    frame(0, 8'hA5, 0, 1'b0, 1, -1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (pin[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    chk("no_refire_en_high", bad, 0);
    en[0] = 1'b0;
    @(negedge clk);

    frame(1, 8'h01, 1, 1'b1, 2, -1);
    en[1] = 1'b0;
    @(negedge clk);
    frame(1, 8'h03, 1, 1'b0, 2, -1);
    en[1] = 1'b0;
    @(negedge clk);

    frame(0, 8'h3C, 0, 1'b0, 1, 32);
    @(negedge clk);
    frame(0, 8'hFF, 0, 1'b0, 1, -1);

    en[0] = 1'b0;
    @(negedge clk);
    frame(0, 8'h96, 0, 1'b0, 1, -1);
    en[0] = 1'b0;
    @(negedge clk);
    frame(0, 8'h00, 0, 1'b0, 1, -1);
    en[0] = 1'b0;
    @(negedge clk);

    en[0] = 1'b1;
    data[0] = 8'h00;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (pin[0] !== 1'b0 && w < 20);
    chk("rst_mid_start_lat", w, 1);
    repeat (44) @(negedge clk);
    chk("rst_mid_d4_low", 32'(pin[0]), 0);
    en[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_pin", 32'(pin[0]), 1);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    chk("rst_mid_done", 32'(done[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_quiet", 32'({pin[0], busy[0], done[0]}), 32'h4);
    frame(0, 8'hC3, 0, 1'b0, 1, -1);
    en[0] = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
